// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched
// Brief    : Schedules L+R / L-R gain products onto one shared sequential
//            multiplier, with a one-deep sample buffer and a ready timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_sched #(
  parameter int SHIFT   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [17:0] left,
  input  logic signed [17:0] right,
  input  logic        [3:0]  ks,
  input  logic        [3:0]  kd,
  output logic               mult_start,
  output logic signed [17:0] mult_a,
  output logic signed [4:0]  mult_b,
  input  logic               mult_ready,
  input  logic signed [22:0] mult_r,
  output logic signed [17:0] lpr_out,
  output logic signed [17:0] lmr_out,
  output logic               lpr_valid,
  output logic               lmr_valid,
  output logic               overrun,
  output logic               fault
);

  localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);
  localparam logic signed [17:0] c_max   = 18'sh1FFFF;
  localparam logic signed [17:0] c_min   = 18'sh20000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_S = 3'd1,
    WAIT_S  = 3'd2,
    ISSUE_D = 3'd3,
    WAIT_D  = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_wait_cnt;

  // Working pair: the sum is consumed at issue time, so only diff/kd persist.
  logic signed [17:0] r_diff;
  logic        [3:0]  r_kd;

  logic               r_buf_valid;
  logic signed [17:0] r_buf_sum;
  logic signed [17:0] r_buf_diff;
  logic        [3:0]  r_buf_ks;
  logic        [3:0]  r_buf_kd;

  function automatic logic signed [17:0] sat19(input logic signed [18:0] v);
    if (v[18] != v[17]) return v[18] ? c_min : c_max;
    return v[17:0];
  endfunction

  logic signed [18:0] w_raw_sum;
  logic signed [18:0] w_raw_diff;
  logic signed [17:0] w_in_sum;
  logic signed [17:0] w_in_diff;

  assign w_raw_sum  = {left[17], left} + {right[17], right};
  assign w_raw_diff = {left[17], left} - {right[17], right};
  assign w_in_sum   = sat19(w_raw_sum);
  assign w_in_diff  = sat19(w_raw_diff);

  logic signed [22:0] w_shifted;
  logic signed [17:0] w_result;

  assign w_shifted = mult_r >>> SHIFT;

  always_comb begin
    w_result = w_shifted[17:0];
    if (!((&w_shifted[22:17]) || !(|w_shifted[22:17])))
      w_result = w_shifted[22] ? c_min : c_max;
  end

  logic w_in_wait;
  logic w_timeout;
  logic w_pair_done;
  logic w_take_buf;
  logic w_take_in;

  assign w_in_wait   = (r_state == WAIT_S) || (r_state == WAIT_D);
  assign w_timeout   = w_in_wait && !mult_ready && (r_wait_cnt == c_last);
  assign w_pair_done = (r_state == WAIT_D) && mult_ready;
  // The buffer drains whenever the working pair frees up, freeing its slot
  // for a sample arriving in the same cycle.
  assign w_take_buf  = r_buf_valid && ((r_state == IDLE) || w_pair_done || w_timeout);
  assign w_take_in   = sample_valid && (r_state == IDLE) && !r_buf_valid;

  logic signed [17:0] w_next_sum;
  logic signed [17:0] w_next_diff;
  logic        [3:0]  w_next_ks;
  logic        [3:0]  w_next_kd;

  assign w_next_sum  = w_take_buf ? r_buf_sum  : w_in_sum;
  assign w_next_diff = w_take_buf ? r_buf_diff : w_in_diff;
  assign w_next_ks   = w_take_buf ? r_buf_ks   : ks;
  assign w_next_kd   = w_take_buf ? r_buf_kd   : kd;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_diff      <= '0;
      r_kd        <= '0;
      r_buf_valid <= 1'b0;
      r_buf_sum   <= '0;
      r_buf_diff  <= '0;
      r_buf_ks    <= '0;
      r_buf_kd    <= '0;
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      lpr_out     <= '0;
      lmr_out     <= '0;
      lpr_valid   <= 1'b0;
      lmr_valid   <= 1'b0;
      overrun     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      lpr_valid  <= 1'b0;
      lmr_valid  <= 1'b0;
      overrun    <= 1'b0;
      fault      <= 1'b0;

      if (w_take_buf) begin
        r_buf_valid <= sample_valid;
      end else if (sample_valid && !w_take_in) begin
        r_buf_valid <= 1'b1;
        overrun     <= r_buf_valid;
      end
      if (sample_valid && !w_take_in) begin
        r_buf_sum  <= w_in_sum;
        r_buf_diff <= w_in_diff;
        r_buf_ks   <= ks;
        r_buf_kd   <= kd;
      end

      case (r_state)
        IDLE: ;
        ISSUE_S: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_S;
        end
        WAIT_S: begin
          if (mult_ready) begin
            lpr_out    <= w_result;
            lpr_valid  <= 1'b1;
            mult_start <= 1'b1;
            mult_a     <= r_diff;
            mult_b     <= {1'b0, r_kd};
            r_state    <= ISSUE_D;
          end else if (w_timeout) begin
            fault   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
          end
        end
        ISSUE_D: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_D;
        end
        WAIT_D: begin
          if (mult_ready) begin
            lmr_out   <= w_result;
            lmr_valid <= 1'b1;
            r_state   <= IDLE;
          end else if (w_timeout) begin
            fault   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      // Starting a new pair overrides the IDLE fallback chosen above.
      if (w_take_buf || w_take_in) begin
        r_diff     <= w_next_diff;
        r_kd       <= w_next_kd;
        mult_start <= 1'b1;
        mult_a     <= w_next_sum;
        mult_b     <= {1'b0, w_next_ks};
        r_state    <= ISSUE_S;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mult_share_sched.md
MULT_SHARE_SCHED -- requirements
Module: mult_share_sched

Interface
REQ-001 Parameter SHIFT, default 3, is the arithmetic right-shift applied to each product.
REQ-002 Parameter TIMEOUT, default 64, is the maximum number of clock cycles spent waiting for mult_ready per operation.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 sample_valid  input  1  one-cycle strobe; left/right/ks/kd are valid in this cycle.
REQ-006 left  input  18  signed audio sample.
REQ-007 right  input  18  signed audio sample.
REQ-008 ks  input  4  unsigned sum gain.
REQ-009 kd  input  4  unsigned difference gain.
REQ-010 mult_start  output  1  one-cycle start pulse to the shared sequential multiplier.
REQ-011 mult_a  output  18  signed multiplicand.
REQ-012 mult_b  output  5  signed multiplier, always {1'b0, gain}.
REQ-013 mult_ready  input  1  multiplier done level; mult_r is valid while it is high.
REQ-014 mult_r  input  23  signed product mult_a*mult_b.
REQ-015 lpr_out  output  18  scaled L+R result.
REQ-016 lmr_out  output  18  scaled L-R result.
REQ-017 lpr_valid  output  1  one-cycle strobe when lpr_out updates.
REQ-018 lmr_valid  output  1  one-cycle strobe when lmr_out updates.
REQ-019 overrun  output  1  one-cycle pulse when a buffered sample is overwritten.
REQ-020 fault  output  1  one-cycle pulse on multiplier timeout.

Function
REQ-021 On accept, the block SHALL compute sum and difference at 19 bits, saturate each to [-131072, 131071], and latch both together with ks and kd.
REQ-022 FSM states SHALL be IDLE, ISSUE_S, WAIT_S, ISSUE_D, WAIT_D.
REQ-023 Transitions SHALL be: IDLE->ISSUE_S on work available; ISSUE_S->WAIT_S after 1 cycle; WAIT_S->ISSUE_D; ISSUE_D->WAIT_D after 1 cycle; WAIT_D->IDLE or ISSUE_S.
REQ-024 WAIT_S/WAIT_D SHALL advance on the first cycle mult_ready is sampled high.
REQ-025 WAIT_D SHALL go to ISSUE_S if the buffer holds a sample, otherwise to IDLE.
REQ-026 mult_start SHALL be high only in ISSUE_S/ISSUE_D, and exactly one cycle each.
REQ-027 mult_a/mult_b SHALL present sum/{0,ks} from ISSUE_S through WAIT_S, and diff/{0,kd} from ISSUE_D through WAIT_D, held stable.
REQ-028 mult_ready SHALL be ignored outside the WAIT states.
REQ-029 Result SHALL be mult_r >>> SHIFT (floor), saturated to 18-bit signed; it is registered on the advancing edge, with lpr_valid (WAIT_S) or lmr_valid (WAIT_D) high for the following cycle.
REQ-030 lpr_out/lmr_out SHALL hold their value between updates.
REQ-031 sample_valid in IDLE SHALL load the working registers directly.
REQ-032 sample_valid while busy SHALL write a one-deep buffer.
REQ-033 If the buffer is already full, the new sample SHALL overwrite it and overrun SHALL pulse.
REQ-034 If sample_valid coincides with WAIT_D completion while the buffer is full, the buffer SHALL move to the working registers and the new sample SHALL enter the buffer, with no overrun.
REQ-035 A wait counter SHALL reset on entry to each WAIT state.
REQ-036 After TIMEOUT cycles in a WAIT state without mult_ready, fault SHALL pulse, the current pair SHALL be dropped without a valid strobe, and the FSM SHALL go to ISSUE_S (buffer full) or IDLE.
REQ-037 lpr_valid SHALL always precede lmr_valid for the same sample pair; no interleaving of pairs.

Reset
REQ-038 On reset the FSM SHALL go to IDLE, the buffer SHALL empty, and the wait counter SHALL clear.
REQ-039 On reset all outputs (mult_start, mult_a, mult_b, lpr_out, lmr_out, lpr_valid, lmr_valid, overrun, fault) SHALL be 0.
REQ-040 Reset mid-operation SHALL abandon the in-flight pair; a later mult_ready SHALL produce no strobe.
REQ-041 sample_valid during reset SHALL be ignored.

Verification (bench multiplier model: mult_ready rises 5 cycles after mult_start, mult_r = a*b)
REQ-042 left=1000, right=500, ks=8, kd=8 -> lpr_out=1500 strobed, then lmr_out=500 strobed; 2 mult_start pulses.
REQ-043 left=100000, right=100000, ks=1 -> sum saturates to 131071; lpr_out=16383; lmr_out=0 (kd=1).
REQ-044 left=-100000, right=100000, kd=15 -> diff=-131072; product -1966080>>>3=-245760, saturated to lmr_out=-131072.
REQ-045 Three sample_valid pulses 2 cycles apart (A, B, C) -> overrun pulses once at C; outputs for A then C only; B never appears.
REQ-046 Model never raises mult_ready, TIMEOUT=64 -> fault pulses 64 cycles after WAIT_S entry; no valid strobes; FSM IDLE.
REQ-047 reset asserted in WAIT_S, then mult_ready rises -> all outputs 0; no lpr_valid; the next sample processes normally.
